// File: rtl/la_pkg.sv
// Shared constants, serializer state encoding and byte-lane helper for the
// capture-to-host sample path.
package la_pkg;

  localparam int SAMPLE_W         = 32;
  localparam int BYTES_PER_SAMPLE = 4;
  localparam int TIME_W           = 24;
  localparam int BYTE_W           = SAMPLE_W - TIME_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } ser_state_e;

  // Little-endian byte lane idx of a sample word.
  function automatic logic [BYTE_W-1:0] byte_lane(input logic [SAMPLE_W-1:0] w,
                                                  input logic [1:0]          idx);
    return w[int'(idx) * BYTE_W +: BYTE_W];
  endfunction

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read, no array
// reset so it maps onto block RAM.
module sample_ram #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] mem_r [2**ADDR_W];

  // Write port.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_r[i_waddr] <= i_wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge i_clk) begin
    if (i_re) begin
      o_rdata <= mem_r[i_raddr];
    end
  end

endmodule

// File: rtl/sample_fifo_serializer.sv
// Sample FIFO with a byte serializer: buffers {time, data} words and streams
// them out little-endian over a valid/ready handshake.
module sample_fifo_serializer
  import la_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int SAMPLE_W = 32
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_save,
  input  logic [SAMPLE_W-1:0] i_data,
  input  logic                i_flush,
  output logic                o_full,
  output logic                o_empty,
  output logic [ADDR_W:0]     o_count,
  output logic                o_overflow,
  output logic [7:0]          o_byte,
  output logic                o_byte_valid,
  input  logic                i_byte_ready
);

  localparam int         PTR_W    = ADDR_W + 1;
  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_SAMPLE - 1);

  ser_state_e          state_r, state_nxt_s;
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [PTR_W-1:0]    wr_ptr_nxt_s, rd_ptr_nxt_s, count_nxt_s;
  logic                full_nxt_s, empty_nxt_s;
  logic [SAMPLE_W-1:0] word_r, ram_rdata_s;
  logic [1:0]          idx_r;
  logic                wr_en_s, pop_s, load_s, advance_s, drop_valid_s;
  logic                handshake_s, last_byte_s;

  // Full is judged on the registered count, so a pop never makes room for a same-cycle write.
  assign wr_en_s     = i_save & ~o_full & ~i_flush;
  assign handshake_s = o_byte_valid & i_byte_ready;
  assign last_byte_s = (idx_r == LAST_IDX);

  sample_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(SAMPLE_W)
  ) u_ram (
    .i_clk  (i_clk),
    .i_we   (wr_en_s),
    .i_waddr(wr_ptr_r[ADDR_W-1:0]),
    .i_wdata(i_data),
    .i_re   (pop_s),
    .i_raddr(rd_ptr_r[ADDR_W-1:0]),
    .o_rdata(ram_rdata_s)
  );

  // Next pointers and status; flush overrides any write or pop.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (i_flush) begin
      wr_ptr_nxt_s = {PTR_W{1'b0}};
      rd_ptr_nxt_s = {PTR_W{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
    end
    count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
    empty_nxt_s = (wr_ptr_nxt_s == rd_ptr_nxt_s);
    full_nxt_s  = (wr_ptr_nxt_s[ADDR_W] != rd_ptr_nxt_s[ADDR_W]) &&
                  (wr_ptr_nxt_s[ADDR_W-1:0] == rd_ptr_nxt_s[ADDR_W-1:0]);
  end

  // Pointer and status-flag registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      o_count    <= {PTR_W{1'b0}};
      o_full     <= 1'b0;
      o_empty    <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      o_count  <= count_nxt_s;
      o_full   <= full_nxt_s;
      o_empty  <= empty_nxt_s;
      if (i_flush) begin
        o_overflow <= 1'b0;
      end else if (i_save & o_full) begin
        o_overflow <= 1'b1;
      end
    end
  end

  // Serializer state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Serializer next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (i_flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!o_empty) begin
            state_nxt_s = ST_FETCH;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_FETCH: state_nxt_s = ST_SEND;
        ST_SEND: begin
          if (handshake_s && last_byte_s) begin
            state_nxt_s = o_empty ? ST_IDLE : ST_FETCH;
          end else begin
            state_nxt_s = ST_SEND;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Serializer control strobes.
  always_comb begin
    pop_s        = 1'b0;
    load_s       = 1'b0;
    advance_s    = 1'b0;
    drop_valid_s = 1'b0;
    if (i_flush) begin
      pop_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE:  pop_s  = ~o_empty;
        ST_FETCH: load_s = 1'b1;
        ST_SEND: begin
          if (handshake_s && last_byte_s) begin
            drop_valid_s = 1'b1;
            pop_s        = ~o_empty;
          end else if (handshake_s) begin
            advance_s = 1'b1;
          end else begin
            advance_s = 1'b0;
          end
        end
        default: pop_s = 1'b0;
      endcase
    end
  end

  // Word holding register and the registered byte handshake outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      word_r       <= {SAMPLE_W{1'b0}};
      idx_r        <= 2'd0;
      o_byte       <= 8'd0;
      o_byte_valid <= 1'b0;
    end else if (i_flush) begin
      idx_r        <= 2'd0;
      o_byte       <= 8'd0;
      o_byte_valid <= 1'b0;
    end else if (load_s) begin
      word_r       <= ram_rdata_s;
      idx_r        <= 2'd0;
      o_byte       <= byte_lane(ram_rdata_s, 2'd0);
      o_byte_valid <= 1'b1;
    end else if (advance_s) begin
      idx_r  <= idx_r + 2'd1;
      o_byte <= byte_lane(word_r, idx_r + 2'd1);
    end else if (drop_valid_s) begin
      o_byte_valid <= 1'b0;
    end
  end

endmodule
